// File: rtl/fb_pkg.sv
// Purpose: shared constants and state encoding for the framebuffer write engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: WIDTH, HEIGHT, ADDR_W, BANKS, PIX_W, BANK_W and the engine state enum.
package fb_pkg;
  localparam int WIDTH  = 200;
  localparam int HEIGHT = 320;
  localparam int ADDR_W = 14;
  localparam int BANKS  = 4;
  localparam int PIX_W  = 16;
  localparam int BANK_W = $clog2(BANKS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FILL  = 2'd2
  } state_t;
endpackage

// File: rtl/fb_addr_split.sv
// Purpose: map a linear pixel index onto {one-hot bank select, bank-local address}.
// Latency: combinational; the caller registers the result.
// Backpressure: none.
// Ports: pix (linear pixel index) -> bank_we (one-hot bank), addr (address within bank).
// The scan-out read path instantiates this too, so reads and writes agree on the layout.
module fb_addr_split
  import fb_pkg::*;
(
  input  logic [PIX_W-1:0]  pix,
  output logic [BANKS-1:0]  bank_we,
  output logic [ADDR_W-1:0] addr
);

  always_comb begin
    bank_we = '0;
    bank_we[pix[ADDR_W +: BANK_W]] = 1'b1;
    addr = pix[ADDR_W-1:0];
  end

endmodule

// File: rtl/fb_rect_writer.sv
// Purpose: rectangle-fill engine driving port B of the 1-bit framebuffer banks.
// Latency: accept at N, first write at N+2, done at N+2+w*h (one write per clock).
// Backpressure: cmd_ready only in IDLE; writes are never stalled.
// Ports: clk, reset (sync, active-high); cmd_valid/cmd_ready + cmd_x/y/w/h/color in;
//        wr_addr, wr_bank_we (one-hot), wr_data to the banks; busy, done status.
// Build option: define FB_CLIP_EN to clip rectangles to the screen in SETUP.
module fb_rect_writer
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_x,
  input  logic [8:0]        cmd_y,
  input  logic [7:0]        cmd_w,
  input  logic [8:0]        cmd_h,
  input  logic              cmd_color,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [BANKS-1:0]  wr_bank_we,
  output logic              wr_data,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [7:0]        x_q, x_d, w_q, w_d, col_q, col_d;
  logic [8:0]        y_q, y_d, h_q, h_d, row_q, row_d;
  logic              color_q, color_d;
  logic [PIX_W-1:0]  row_base_q, row_base_d;
  logic [ADDR_W-1:0] addr_d;
  logic [BANKS-1:0]  we_d;
  logic              data_d, done_d;

  logic [7:0]        eff_w;
  logic [8:0]        eff_h;
  logic [PIX_W-1:0]  first_pix;
  logic [PIX_W-1:0]  pix_d;
  logic [BANKS-1:0]  split_we;
  logic [ADDR_W-1:0] split_addr;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  // The only multiply: start of the first row, truncated so it wraps mod 2**16.
  assign first_pix = PIX_W'(32'(y_q) * 32'(WIDTH) + 32'(x_q));

  // Effective extent of the latched command.
  always_comb begin
    eff_w = w_q;
    eff_h = h_q;
`ifdef FB_CLIP_EN
    if (32'(x_q) >= WIDTH || 32'(y_q) >= HEIGHT) begin
      eff_w = '0;
      eff_h = '0;
    end else begin
      if (32'(w_q) > WIDTH - 32'(x_q))  eff_w = 8'(WIDTH - 32'(x_q));
      if (32'(h_q) > HEIGHT - 32'(y_q)) eff_h = 9'(HEIGHT - 32'(y_q));
    end
`endif
  end

  fb_addr_split u_split (
    .pix     (pix_d),
    .bank_we (split_we),
    .addr    (split_addr)
  );

  // Next-state and next-output logic. The write outputs are registered, so
  // this computes the pixel that will be on the bus during the next cycle.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    row_base_d = row_base_q;
    col_d      = col_q;
    row_d      = row_q;
    pix_d      = '0;
    we_d       = '0;
    addr_d     = wr_addr;
    data_d     = wr_data;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          x_d     = cmd_x;
          y_d     = cmd_y;
          w_d     = cmd_w;
          h_d     = cmd_h;
          color_d = cmd_color;
          state_d = SETUP;
        end
      end

      SETUP: begin
        row_base_d = first_pix;
        col_d      = '0;
        row_d      = '0;
        w_d        = eff_w;
        h_d        = eff_h;
        if (eff_w == '0 || eff_h == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = FILL;
          pix_d   = first_pix;
          we_d    = split_we;
          addr_d  = split_addr;
          data_d  = color_q;
        end
      end

      FILL: begin
        if (col_q == w_q - 8'd1) begin
          if (row_q == h_q - 9'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            // Step to the next row by addition; no multiply in the fill loop.
            col_d      = '0;
            row_d      = row_q + 9'd1;
            row_base_d = row_base_q + PIX_W'(WIDTH);
            pix_d      = row_base_q + PIX_W'(WIDTH);
            we_d       = split_we;
            addr_d     = split_addr;
            data_d     = color_q;
          end
        end else begin
          col_d  = col_q + 8'd1;
          pix_d  = row_base_q + PIX_W'(col_q) + PIX_W'(1);
          we_d   = split_we;
          addr_d = split_addr;
          data_d = color_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= 1'b0;
      row_base_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      wr_addr    <= '0;
      wr_bank_we <= '0;
      wr_data    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      row_base_q <= row_base_d;
      col_q      <= col_d;
      row_q      <= row_d;
      wr_addr    <= addr_d;
      wr_bank_we <= we_d;
      wr_data    <= data_d;
      done       <= done_d;
    end
  end

endmodule
